// File: rtl/instr_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit_if
// Groups the instruction-memory read bus and the decode-side handshake of the
// fetch unit.
//   imem_req/imem_addr      fetch -> memory  read request and word address
//   imem_gnt                memory -> fetch  request accepted this cycle
//   imem_rvalid/imem_rdata  memory -> fetch  read response
//   instr_valid/data/pc     fetch -> decode  fetched instruction and its address
//   decode_ready            decode -> fetch  instruction accepted
// Modports: master = fetch unit, slave = memory/decode side.
// ----------------------------------------------------------------------------
interface instr_fetch_unit_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;
    logic              instr_valid;
    logic [DATA_W-1:0] instr_data;
    logic [ADDR_W-1:0] instr_pc;
    logic              decode_ready;

    modport master (
        output imem_req, imem_addr, instr_valid, instr_data, instr_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, decode_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr_data, instr_pc,
        output imem_gnt, imem_rvalid, imem_rdata, decode_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
// Owns the PC, issues one word read at a time to instruction memory and hands
// each instruction, tagged with its address, to decode over valid/ready.
// Branch redirects take priority over everything; stall only blocks new issue.
//
// Ports:
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   stall          blocks IDLE->REQ and HOLD->REQ
//   branch_valid   one-cycle redirect strobe
//   branch_target  redirect address
//   stall_cycles   (FETCH_PERF_CNT_EN only) saturating stall/back-pressure count
//   bus            instr_fetch_unit_if.master: memory bus and decode handshake
//
// Optional feature macro: FETCH_PERF_CNT_EN
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               stall,
    input  logic               branch_valid,
    input  logic [ADDR_W-1:0]  branch_target,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0]        stall_cycles,
`endif
    instr_fetch_unit_if.master bus
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

    localparam logic [ADDR_W-1:0] PcOne = 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              req_q, req_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;
    logic              squash_q, squash_d;
    logic              grant;

    // A grant only counts while we are actually requesting.
    assign grant = req_q & bus.imem_gnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            ipc_q    <= '0;
            squash_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_q    <= req_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            ipc_q    <= ipc_d;
            squash_q <= squash_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        data_d   = data_q;
        ipc_d    = ipc_q;
        squash_d = squash_q;

        // The response to a redirected-away fetch is swallowed here.
        if (squash_q && bus.imem_rvalid) begin
            squash_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (!stall) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                // rvalid is deliberately ignored here, including the grant cycle.
                if (grant) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (bus.imem_rvalid) begin
                    data_d  = bus.imem_rdata;
                    ipc_d   = pc_q;
                    valid_d = 1'b1;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (bus.decode_ready) begin
                    valid_d = 1'b0;
                    pc_d    = pc_q + PcOne;
                    state_d = stall ? StIdle : StReq;
                end
            end
            default: state_d = StIdle;
        endcase

        if (branch_valid) begin
            pc_d    = branch_target;
            valid_d = 1'b0;
            state_d = stall ? StIdle : StReq;
            if (state_q == StReq && grant) begin
                squash_d = 1'b1;
            end
            // A response landing in the redirect cycle is already dropped, so
            // only arm the squash if it is still outstanding.
            if (state_q == StWait) begin
                squash_d = !bus.imem_rvalid;
            end
        end
    end

    // Request is a register; hold it off while an old response is pending.
    assign req_d = (state_d == StReq) && !squash_d;

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr_data  = data_q;
    assign bus.instr_pc    = ipc_q;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (((stall && state_q == StIdle) || (req_q && !bus.imem_gnt))
                     && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign stall_cycles = cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Drives instr_fetch_unit with a behavioural instruction memory (one
// outstanding read, programmable grant rate and response delay) and compares
// against an architectural model: the PC follows branch/accept events, every
// presented instruction must be the memory word at its tag, held instructions
// stay stable, and no request may overlap an outstanding response.
// ----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          stall = 1'b0;
    logic          branch_valid = 1'b0;
    logic [AW-1:0] branch_target = '0;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0]   stall_cycles;
`endif

    instr_fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

    instr_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(8'h00)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall         (stall),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
`ifdef FETCH_PERF_CNT_EN
        .stall_cycles  (stall_cycles),
`endif
        .bus           (bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int accepts = 0;

    // stimulus knobs
    bit rnd_mode = 1'b0;
    int gnt_pct = 100, rdy_pct = 50, stall_pct = 0, br_pct = 0;
    int dly_min = 1, dly_max = 1;
    bit junk_rvalid = 1'b0;
    bit drv_stall = 1'b0, drv_ready = 1'b0, drv_branch = 1'b0;
    logic [AW-1:0] drv_target = '0;

    // memory model
    bit            mem_busy = 1'b0;
    int            mem_due = 0;
    logic [AW-1:0] mem_addr = '0;

    // architectural reference
    logic [AW-1:0] pc_exp = '0;
    bit            prev_branch = 1'b0, prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [AW-1:0] prev_pc = '0;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return 32'hF8400000 ^ {8'h00, a, 8'h00, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: called at posedge+1, drives inputs, checks, advances.
    task automatic tick();
        logic g, rv, accept;
        if (rnd_mode) begin
            stall = ($urandom_range(99) < stall_pct);
            bus_if.decode_ready = ($urandom_range(99) < rdy_pct);
            branch_valid = ($urandom_range(99) < br_pct);
            branch_target = AW'($urandom);
        end else begin
            stall = drv_stall;
            bus_if.decode_ready = drv_ready;
            branch_valid = drv_branch;
            branch_target = drv_target;
            drv_branch = 1'b0;
        end

        rv = mem_busy && (cyc == mem_due);
        g  = !mem_busy && ($urandom_range(99) < gnt_pct);
        bus_if.imem_gnt = g;
        bus_if.imem_rvalid = rv;
        bus_if.imem_rdata = rv ? mem_word(mem_addr) : 32'h0BAD_F00D;
        // Stray response on the grant cycle must be ignored by the fetch unit.
        if (junk_rvalid && g && bus_if.imem_req && ($urandom_range(1) == 1)) begin
            bus_if.imem_rvalid = 1'b1;
            bus_if.imem_rdata = ~mem_word(bus_if.imem_addr);
        end

        chk("pc_tracks", bus_if.imem_addr, pc_exp);
        chk("no_req_outstanding", bus_if.imem_req && mem_busy, 0);
        chk("no_req_while_valid", bus_if.imem_req && bus_if.instr_valid, 0);
        if (prev_branch) chk("dropped_after_branch", bus_if.instr_valid, 0);
        if (prev_hold) begin
            chk("hold_valid", bus_if.instr_valid, 1);
            chk("hold_data", bus_if.instr_data, prev_data);
            chk("hold_pc", bus_if.instr_pc, prev_pc);
        end
        if (bus_if.instr_valid) begin
            chk("instr_pc", bus_if.instr_pc, pc_exp);
            chk("instr_data", bus_if.instr_data, mem_word(bus_if.instr_pc));
        end

        if (rv) mem_busy = 1'b0;
        if (bus_if.imem_req && g) begin
            mem_busy = 1'b1;
            mem_addr = bus_if.imem_addr;
            mem_due = cyc + int'($urandom_range(dly_max, dly_min));
        end
        accept = bus_if.instr_valid && bus_if.decode_ready;
        if (branch_valid) pc_exp = branch_target;
        else if (accept) begin
            pc_exp = pc_exp + 8'd1;
            accepts++;
        end
        prev_branch = branch_valid;
        prev_hold = bus_if.instr_valid && !bus_if.decode_ready && !branch_valid;
        prev_data = bus_if.instr_data;
        prev_pc = bus_if.instr_pc;

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_valid(input int max);
        int n = 0;
        while (!bus_if.instr_valid && n < max) begin
            tick();
            n++;
        end
        chk("wait_valid_timeout", bus_if.instr_valid, 1);
    endtask

    // Entered at posedge+1; reset asserts mid-cycle so the checks see the
    // asynchronous clear before any clock edge.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_req", bus_if.imem_req, 0);
        chk("rst_addr", bus_if.imem_addr, 8'h00);
        chk("rst_valid", bus_if.instr_valid, 0);
        chk("rst_data", bus_if.instr_data, 0);
        chk("rst_pc", bus_if.instr_pc, 0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_stall_cycles", stall_cycles, 0);
`endif
        stall = 1'b0;
        branch_valid = 1'b0;
        bus_if.decode_ready = 1'b0;
        bus_if.imem_gnt = 1'b0;
        bus_if.imem_rvalid = 1'b0;
        bus_if.imem_rdata = '0;
        mem_busy = 1'b0;
        pc_exp = 8'h00;
        prev_branch = 1'b0;
        prev_hold = 1'b0;
        drv_stall = 1'b0;
        drv_ready = 1'b0;
        drv_branch = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [AW-1:0] p;
        bus_if.imem_gnt = 1'b0;
        bus_if.imem_rvalid = 1'b0;
        bus_if.imem_rdata = '0;
        bus_if.decode_ready = 1'b0;
        @(posedge clk);
        #1;

        // First fetch latency with grant tied high, response one cycle later
        do_reset();
        gnt_pct = 100; dly_min = 1; dly_max = 1;
        tick();
        chk("c1_req", bus_if.imem_req, 1);
        chk("c1_addr", bus_if.imem_addr, 8'h00);
        tick();
        chk("c2_req_dropped", bus_if.imem_req, 0);
        chk("c2_not_valid", bus_if.instr_valid, 0);
        tick();
        chk("c3_valid", bus_if.instr_valid, 1);
        chk("c3_pc", bus_if.instr_pc, 8'h00);
        chk("c3_data", bus_if.instr_data, 32'hF8400000);
        drv_ready = 1'b1;
        tick();
        drv_ready = 1'b0;
        chk("c4_valid_dropped", bus_if.instr_valid, 0);
        chk("c4_req", bus_if.imem_req, 1);
        chk("c4_addr", bus_if.imem_addr, 8'h01);

        // Grant withheld for four cycles
        do_reset();
        gnt_pct = 0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("nogrant_req", bus_if.imem_req, 1);
            chk("nogrant_addr", bus_if.imem_addr, 8'h00);
            tick();
        end
`ifdef FETCH_PERF_CNT_EN
        chk("stall_cycles_4", stall_cycles, 16'd4);
`endif
        chk("nogrant_req_still", bus_if.imem_req, 1);
        gnt_pct = 100;
        wait_valid(20);

        // Decode back-pressure for five cycles
        d = bus_if.instr_data;
        p = bus_if.instr_pc;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", bus_if.instr_valid, 1);
            chk("bp_data", bus_if.instr_data, d);
            chk("bp_pc", bus_if.instr_pc, p);
            chk("bp_no_req", bus_if.imem_req, 0);
            tick();
        end
        drv_ready = 1'b1;
        tick();
        drv_ready = 1'b0;
        chk("bp_accepted", bus_if.instr_valid, 0);

        // Redirect while waiting on the 0x10 response
        do_reset();
        gnt_pct = 100; dly_min = 2; dly_max = 2;
        drv_branch = 1'b1; drv_target = 8'h10;
        tick();
        chk("br_addr10", bus_if.imem_addr, 8'h10);
        chk("br_req10", bus_if.imem_req, 1);
        tick();
        chk("br_wait", bus_if.imem_req, 0);
        drv_branch = 1'b1; drv_target = 8'h40;
        tick();
        chk("br_addr40", bus_if.imem_addr, 8'h40);
        chk("br_squash_no_req", bus_if.imem_req, 0);
        tick();
        chk("br_req40", bus_if.imem_req, 1);
        chk("br_req40_addr", bus_if.imem_addr, 8'h40);
        dly_min = 1; dly_max = 1;
        wait_valid(20);
        chk("br_first_pc", bus_if.instr_pc, 8'h40);
        chk("br_first_data", bus_if.instr_data, mem_word(8'h40));
        drv_ready = 1'b1;
        tick();
        drv_ready = 1'b0;

        // PC wrap; the redirect here also lands on a grant cycle
        drv_branch = 1'b1; drv_target = 8'hFF;
        tick();
        wait_valid(20);
        chk("wrap_pc", bus_if.instr_pc, 8'hFF);
        drv_ready = 1'b1;
        tick();
        drv_ready = 1'b0;
        chk("wrap_addr", bus_if.imem_addr, 8'h00);

        // Stall during HOLD, then accept
        wait_valid(20);
        p = bus_if.instr_pc + 8'd1;
        drv_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold_valid", bus_if.instr_valid, 1);
        end
        drv_ready = 1'b1;
        tick();
        drv_ready = 1'b0;
        chk("stall_accept_drop", bus_if.instr_valid, 0);
        for (int i = 0; i < 3; i++) begin
            chk("stall_no_req", bus_if.imem_req, 0);
            tick();
        end
        chk("stall_addr_next", bus_if.imem_addr, p);
        drv_stall = 1'b0;
        tick();
        chk("unstall_req", bus_if.imem_req, 1);
        chk("unstall_addr", bus_if.imem_addr, p);

        // Branch and accept together in HOLD: branch wins
        wait_valid(20);
        drv_ready = 1'b1; drv_branch = 1'b1; drv_target = 8'h80;
        tick();
        drv_ready = 1'b0;
        chk("br_accept_valid", bus_if.instr_valid, 0);
        chk("br_accept_addr", bus_if.imem_addr, 8'h80);

        // Reset in the middle of a held instruction
        wait_valid(20);
        do_reset();

        // Randomized traffic against the reference model
        rnd_mode = 1'b1;
        gnt_pct = 60; rdy_pct = 60; stall_pct = 20; br_pct = 5;
        dly_min = 1; dly_max = 3; junk_rvalid = 1'b1;
        accepts = 0;
        repeat (3000) tick();
        chk("random_progress", accepts >= 100, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
